// File: rtl/booth_dot_accumulator_if.sv
// Handshake bundle for booth_dot_accumulator: product input stream and result output stream.
// master drives products and result-ready; slave is the accumulator.
interface booth_dot_accumulator_if #(
  parameter int PROD_W = 12,
  parameter int ACC_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     out_overflow;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );
endinterface

// File: rtl/booth_dot_accumulator.sv
// Accumulates groups of COUNT signed products into one signed dot-product result.
// Two-state FSM: ACCUM takes products, HOLD presents the result until accepted.
// Optional macro BOOTH_ACC_SATURATE_EN: clamp the accumulator on signed overflow instead of
// wrapping. The overflow flag is reported the same way in both builds.
module booth_dot_accumulator #(
  parameter int PROD_W = 12,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input logic                    clk,
  input logic                    rst,
  booth_dot_accumulator_if.slave bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {
    StAccum = 1'b0,
    StHold  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic                    r_out_ovf;

  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_add_ovf;
  logic                    w_ovf_next;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_in_ready;
  logic                    w_out_valid;

  // Sign-extend the product and form the wrapped sum plus its overflow flag.
  always_comb begin
    w_ext      = ACC_W'($signed(bus.in_product));
    w_sum      = r_acc + w_ext;
    w_add_ovf  = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    w_ovf_next = r_ovf | w_add_ovf;
`ifdef BOOTH_ACC_SATURATE_EN
    // Both operands share a sign on overflow, so the product sign picks the rail.
    if (w_add_ovf) begin
      w_acc_next = w_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_acc_next = w_sum;
    end
`else
    w_acc_next = w_sum;
`endif
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt == CNT_W'(COUNT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StAccum: if (w_accept && w_last) w_state_next = StHold;
      StHold:  if (bus.out_ready)      w_state_next = StAccum;
      default: w_state_next = StAccum;
    endcase
  end

  // FSM outputs; in_ready depends on state and reset only, never on in_valid.
  always_comb begin
    w_in_ready  = (r_state == StAccum) && !rst;
    w_out_valid = (r_state == StHold);
  end

  // Accumulator, group counter, sticky overflow and the captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_sum <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_out_sum <= w_acc_next;
        r_out_ovf <= w_ovf_next;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= w_ovf_next;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_sum      = r_out_sum;
  assign bus.out_overflow = r_out_ovf;

endmodule
